fp_norm_unit: RTL
=================

// Module: fp_norm_unit
// PURPOSE
// - Post-add normaliser for the FP32 add/sub path. It is the counterpart of the pre-add exponent-difference/alignment
//   stage: it takes the raw signed-magnitude mantissa sum plus the larger operand's biased exponent, and returns a packed FP32 word.
// - Sequential and iterative: 1-bit right shift on carry-out, or left shifts of up to SHIFT_STEP bits/cycle on cancellation.
// - Then round, then hold the result under a valid/ready handshake.
// PARAMETERS
// - EXP_W       8   exponent field width
// - FRAC_W      23  fraction field width; mantissa input is FRAC_W+4 bits
// - SHIFT_STEP  1   max left-shift positions per SHIFT cycle; legal values 1, 2, 4
// PORTS
// - i_clk        in   1         clock
// - i_rst_n      in   1         async active-low reset
// - i_valid      in   1         input operand valid
// - o_ready      out  1         block can accept (high only in IDLE)
// - i_sign       in   1         result sign
// - i_exp        in   EXP_W     biased exponent of larger operand, 1..2^EXP_W-2 (0 treated as 1)
// - i_mant       in   FRAC_W+4  [26]=carry, [25]=hidden, [24:2]=frac, [1]=guard, [0]=sticky
// - o_valid      out  1         result valid; held until i_ready
// - i_ready      in   1         downstream accepts
// - o_result     out  32        {sign, exp field, frac}
// - o_overflow   out  1         result is +/-inf from exponent overflow
// - o_underflow  out  1         result is subnormal (exp field 0, frac != 0)
// - o_zero       out  1         result is +/-0
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; o_valid, o_result and all flags = 0; o_ready=1 after release. In-flight op discarded.
// - IDLE: capture on i_valid&o_ready. Next state CHECK.
// - CHECK, priority order:
//   - mant==0 -> result {sign,0}, o_zero=1 -> DONE.
//   - mant[26] -> shift mant right 1 (OR the shifted-out bit into sticky), exp+1.
//     - If exp becomes 2^EXP_W-1 -> {sign,all-ones,0}, o_overflow=1 -> DONE.
//     - Otherwise -> ROUND.
//   - mant[25] -> ROUND.
//   - Otherwise -> SHIFT.
// - SHIFT: each cycle, shift left by k = min(leading zeros above bit 25, SHIFT_STEP, exp-1); exp -= k. Zeros enter at bit 0; sticky is kept.
//   - Exit to ROUND when mant[25]=1 or exp==1. Exit with hidden=0 means subnormal.
// - ROUND: round_up = G&(S|frac[0]) (macro below); frac += round_up.
//   - Fraction carry into hidden: a subnormal becomes normal (exp stays 1).
//   - Carry out of hidden: frac=0, exp+1; on reaching all-ones -> overflow result.
//   - -> DONE.
// - Exp field = hidden ? exp : 0. o_underflow = (field==0 && frac!=0).
// - DONE: o_valid=1; o_result and flags stable until o_valid&i_ready -> IDLE. No overlap: next accept at earliest the cycle after handoff.
// - Latency: o_valid rises 2+m edges after the accepting edge, m = SHIFT cycles.
//   - Zero and CHECK-overflow: 1 edge.
// - Exponent arithmetic uses EXP_W+1 bits internally to detect wrap. Exp never decrements below 1.
// CONFIGURATION
// - FP_NORM_RNE_EN defined: round-to-nearest-even as above.
// - Not defined: truncation, round_up tied 0. The ROUND cycle is still taken, so latency is identical.
// STRUCTURE
// - fp32_pkg:
//   - norm_state_e {IDLE,CHECK,SHIFT,ROUND,DONE}
//   - EXP_BIAS=127, EXP_MAX=8'hFF
//   - fp32_t packed struct {sign,exp,frac}
// - Sub-module fp_lzd_step: counts leading zeros in mant[25 -: SHIFT_STEP], saturating at SHIFT_STEP.
// TESTING
// - mant=27'h4000000, exp=8'h7F, sign=0 -> 0x40000000, flags 0, o_valid 2 edges after accept.
// - mant=27'h0000004, exp=8'h7F, SHIFT_STEP=1 -> 0x34000000 after 25 edges; with SHIFT_STEP=4 -> same result in 8 edges.
// - mant=27'h0800000, exp=8'h02 -> 0x00400000, o_underflow=1.
// - mant=27'h4000000, exp=8'hFE -> 0x7F800000, o_overflow=1. Separately, mant=0, sign=1 -> 0x80000000, o_zero=1.
// - mant=27'h3FFFFFF, exp=8'h7F -> 0x40000000 with FP_NORM_RNE_EN; 0x3FFFFFFF without it.
// - Handshake and reset:
//   - Hold i_ready=0 for 3 cycles in DONE -> o_result stable, o_ready=0.
//   - Assert i_rst_n=0 mid-SHIFT -> outputs 0 immediately, IDLE, next op correct.

Source files
------------

// File: rtl/fp32_pkg.sv
// ----------------------------------------------------------------------------
// fp32_pkg : shared types and constants for the FP32 add/sub normaliser
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp32_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SHIFT = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } norm_state_e;

  localparam int         EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

`default_nettype wire

// File: rtl/fp_lzd_step.sv
// ----------------------------------------------------------------------------
// fp_lzd_step : leading-zero count over one shift window, saturating at SHIFT_STEP
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_lzd_step #(
  parameter int SHIFT_STEP = 1
) (
  input  logic [SHIFT_STEP-1:0] bits,
  output logic [2:0]            count
);

  // Last assignment wins, so the highest set bit decides the count.
  always_comb begin
    count = 3'(SHIFT_STEP);
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (bits[i]) count = 3'(SHIFT_STEP - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_norm_unit.sv
// ----------------------------------------------------------------------------
// fp_norm_unit : iterative post-add normaliser/rounder producing a packed FP32 word
// Config       : FP_NORM_RNE_EN selects round-to-nearest-even, else truncation
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_norm_unit
  import fp32_pkg::*;
#(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int SHIFT_STEP = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [FRAC_W+3:0] i_mant,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_result,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_zero
);

  localparam int MW = FRAC_W + 4;
  localparam int RW = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE  = (EXP_W+1)'(1);

  norm_state_e state_q, state_d;

  logic              sign_q;
  logic [EXP_W:0]    exp_q;
  logic [MW-1:0]     mant_q;
  logic [RW-1:0]     result_q;
  logic              ovf_q, unf_q, zero_q;

  logic [2:0]        lz;
  logic [2:0]        k;
  logic [EXP_W:0]    exp_room, exp_lsub, exp_inc, rnd_exp;
  logic [MW-1:0]     mant_lshift, mant_rshift;
  logic              round_up;
  logic [FRAC_W+1:0] sig_sum;
  logic              rnd_hidden;
  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W-1:0]  rnd_field;

  fp_lzd_step #(.SHIFT_STEP(SHIFT_STEP)) u_lzd (
    .bits  (mant_q[MW-2 -: SHIFT_STEP]),
    .count (lz)
  );

  always_comb begin
    exp_inc     = exp_q + EXP_ONE;
    mant_rshift = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
    exp_room    = exp_q - EXP_ONE;
    // Never let the exponent drop below 1: the step is clipped to the headroom.
    k           = ((EXP_W+1)'(lz) > exp_room) ? exp_room[2:0] : lz;
    mant_lshift = mant_q << k;
    exp_lsub    = exp_q - (EXP_W+1)'(k);
`ifdef FP_NORM_RNE_EN
    round_up    = mant_q[1] & (mant_q[0] | mant_q[2]);
`else
    round_up    = 1'b0;
`endif
    sig_sum     = {1'b0, mant_q[MW-2:2]} + (FRAC_W+2)'(round_up);
    rnd_exp     = exp_q + (EXP_W+1)'(sig_sum[FRAC_W+1]);
    rnd_hidden  = sig_sum[FRAC_W+1] | sig_sum[FRAC_W];
    rnd_frac    = sig_sum[FRAC_W+1] ? '0 : sig_sum[FRAC_W-1:0];
    rnd_field   = rnd_hidden ? rnd_exp[EXP_W-1:0] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (i_valid) state_d = CHECK;
      CHECK: begin
        if (mant_q == '0)        state_d = DONE;
        else if (mant_q[MW-1])   state_d = (exp_inc == EXP_ONES) ? DONE : ROUND;
        else if (mant_q[MW-2])   state_d = ROUND;
        else                     state_d = SHIFT;
      end
      SHIFT: if (mant_lshift[MW-2] || exp_lsub == EXP_ONE) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          sign_q <= i_sign;
          exp_q  <= (i_exp == '0) ? EXP_ONE : {1'b0, i_exp};
          mant_q <= i_mant;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
          zero_q <= 1'b0;
        end
        CHECK: begin
          if (mant_q == '0) begin
            result_q <= {sign_q, {(RW-1){1'b0}}};
            zero_q   <= 1'b1;
          end else if (mant_q[MW-1]) begin
            mant_q <= mant_rshift;
            exp_q  <= exp_inc;
            if (exp_inc == EXP_ONES) begin
              result_q <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              ovf_q    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          mant_q <= mant_lshift;
          exp_q  <= exp_lsub;
        end
        ROUND: begin
          if (rnd_exp == EXP_ONES) begin
            result_q <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, rnd_field, rnd_frac};
            unf_q    <= (rnd_field == '0) && (rnd_frac != '0);
            zero_q   <= (rnd_field == '0) && (rnd_frac == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ready     = (state_q == IDLE);
    o_valid     = (state_q == DONE);
    o_result    = 32'(result_q);
    o_overflow  = ovf_q;
    o_underflow = unf_q;
    o_zero      = zero_q;
  end

endmodule

`default_nettype wire
